// File: rtl/seg_number_formatter.sv
// rtl/seg_number_formatter.sv - signed 16-bit value plus prefix to eight seven-segment character slots

// Character codes shared with seven_seg_display_driver; digits sit at their own numeric value.
typedef enum logic [4:0] {
  CHAR_0    = 5'd0,
  CHAR_1    = 5'd1,
  CHAR_2    = 5'd2,
  CHAR_3    = 5'd3,
  CHAR_4    = 5'd4,
  CHAR_5    = 5'd5,
  CHAR_6    = 5'd6,
  CHAR_7    = 5'd7,
  CHAR_8    = 5'd8,
  CHAR_9    = 5'd9,
  CHAR_A    = 5'd10,
  CHAR_B    = 5'd11,
  CHAR_C    = 5'd12,
  CHAR_D    = 5'd13,
  CHAR_E    = 5'd14,
  CHAR_F    = 5'd15,
  CHAR_H    = 5'd16,
  CHAR_L    = 5'd17,
  CHAR_P    = 5'd18,
  CHAR_U    = 5'd19,
  CHAR_DASH = 5'd20,
  CHAR_BLK  = 5'd21
} code_t;

module seg_number_formatter #(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [15:0]     value,
  input  code_t [1:0]     prefix,
  input  logic [7:0]      blink_sel,
  output code_t [7:0]     display_data,
  output logic [7:0]      blink_mask,
  output logic            busy
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_FMT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          accept;

  logic [15:0]   mag;
  logic [19:0]   bcd;
  logic [19:0]   bcd_adj;
  logic [3:0]    iter;
  logic          neg;
  code_t [1:0]   prefix_q;
  logic [7:0]    blink_sel_q;

  code_t [7:0]   fmt_data;
  logic [4:0]    keep;

  logic [CW-1:0] blink_cnt;
  logic [CW-1:0] blink_cnt_nxt;
  logic          phase;
  logic          phase_nxt;
  logic [7:0]    blink_active;
  logic [7:0]    blink_active_nxt;

  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;

  // One display slot: a digit when significant, otherwise the sign dash or a blank.
  function automatic code_t slot_char(input logic [3:0] d, input logic show, input logic dash);
    if (show) begin
      return code_t'({1'b0, d});
    end else if (dash) begin
      return CHAR_DASH;
    end else begin
      return CHAR_BLK;
    end
  endfunction

  // State register; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, 16 shift cycles, one format cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (iter == 4'd15) begin
          state_nxt = S_FMT;
        end
      end
      S_FMT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Double-dabble correction: any BCD nibble of 5 or more gets 3 added before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Request latch and shift engine; magnitude of -32768 is 16'h8000 read as unsigned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag         <= 16'd0;
      bcd         <= 20'd0;
      iter        <= 4'd0;
      neg         <= 1'b0;
      prefix_q[1] <= CHAR_BLK;
      prefix_q[0] <= CHAR_BLK;
      blink_sel_q <= 8'd0;
    end else if (accept) begin
      mag         <= value[15] ? (~value + 16'd1) : value;
      bcd         <= 20'd0;
      iter        <= 4'd0;
      neg         <= value[15];
      prefix_q    <= prefix;
      blink_sel_q <= blink_sel;
    end else if (state == S_CONV) begin
      {bcd, mag} <= {bcd_adj, mag} << 1;
      iter       <= iter + 4'd1;
    end
  end

  // keep[i] is set when digit i or any higher digit is non-zero; slot 0 always shows.
  always_comb begin
    keep    = 5'd0;
    keep[4] = |bcd[19:16];
    keep[3] = keep[4] | (|bcd[15:12]);
    keep[2] = keep[3] | (|bcd[11:8]);
    keep[1] = keep[2] | (|bcd[7:4]);
    keep[0] = 1'b1;
  end

  // Slot assembly: prefix, then the dash just left of the most significant digit, then digits.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      fmt_data[i] = CHAR_BLK;
    end
    fmt_data[7] = prefix_q[1];
    fmt_data[6] = prefix_q[0];
    fmt_data[5] = slot_char(4'd0,        1'b0,    neg & keep[4]);
    fmt_data[4] = slot_char(bcd[19:16],  keep[4], neg & ~keep[4] & keep[3]);
    fmt_data[3] = slot_char(bcd[15:12],  keep[3], neg & ~keep[3] & keep[2]);
    fmt_data[2] = slot_char(bcd[11:8],   keep[2], neg & ~keep[2] & keep[1]);
    fmt_data[1] = slot_char(bcd[7:4],    keep[1], neg & ~keep[1] & keep[0]);
    fmt_data[0] = slot_char(bcd[3:0],    1'b1,    1'b0);
  end

  // Display register updates in a single edge so the driver never sees a half-written value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        display_data[i] <= CHAR_DASH;
      end
    end else if (state == S_FMT) begin
      display_data <= fmt_data;
    end
  end

  // Blink timer next state; the format edge restarts it lit so a new value is seen at once.
  always_comb begin
    blink_cnt_nxt    = blink_cnt;
    phase_nxt        = phase;
    blink_active_nxt = blink_active;
    if (state == S_FMT) begin
      blink_cnt_nxt    = '0;
      phase_nxt        = 1'b1;
      blink_active_nxt = blink_sel_q;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt_nxt = '0;
      phase_nxt     = ~phase;
    end else begin
      blink_cnt_nxt = blink_cnt + 1'b1;
    end
  end

  // Blink registers; the mask is computed from next-state values so it tracks phase exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt    <= '0;
      phase        <= 1'b1;
      blink_active <= 8'd0;
      blink_mask   <= 8'hFF;
    end else begin
      blink_cnt    <= blink_cnt_nxt;
      phase        <= phase_nxt;
      blink_active <= blink_active_nxt;
      blink_mask   <= ~blink_active_nxt | {8{phase_nxt}};
    end
  end

endmodule

// File: tb/tb_seg_number_formatter.sv
// tb/tb_seg_number_formatter.sv - directed self-checking bench for seg_number_formatter

module tb_seg_number_formatter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [15:0]   value;
  code_t [1:0]   prefix;
  logic [7:0]    blink_sel;
  code_t [7:0]   display_data;
  logic [7:0]    blink_mask;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_number_formatter #(.BLINK_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .value        (value),
    .prefix       (prefix),
    .blink_sel    (blink_sel),
    .display_data (display_data),
    .blink_mask   (blink_mask),
    .busy         (busy)
  );

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and return how many cycles req_ready stayed low after the accept edge.
  task automatic convert(input logic [15:0] v, input code_t p1, input code_t p0,
                         input logic [7:0] bs, output int lat);
    int n = 0;
    while (!req_ready && n < 40) begin
      step();
      n++;
    end
    req_valid = 1'b1;
    value     = v;
    prefix[1] = p1;
    prefix[0] = p0;
    blink_sel = bs;
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!req_ready && lat < 40) begin
      lat++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    bit seen;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    value     = 16'd0;
    prefix[1] = CHAR_BLK;
    prefix[0] = CHAR_BLK;
    blink_sel = 8'd0;
    step();
    step();
    check("rst_disp",  display_data, {8{CHAR_DASH}});
    check("rst_mask",  blink_mask, 8'hFF);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy",  busy, 1'b0);
    rst_n = 1'b1;
    step();

    convert(16'd1234, CHAR_A, CHAR_BLK, 8'h00, lat);
    check("lat_1234",  lat, 17);
    check("disp_1234", display_data,
          {CHAR_A, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_1, CHAR_2, CHAR_3, CHAR_4});
    check("mask_1234", blink_mask, 8'hFF);

    convert(16'h8000, CHAR_P, CHAR_BLK, 8'h00, lat);
    check("disp_m32768", display_data,
          {CHAR_P, CHAR_BLK, CHAR_DASH, CHAR_3, CHAR_2, CHAR_7, CHAR_6, CHAR_8});

    convert(16'hFFFB, CHAR_P, CHAR_BLK, 8'h00, lat);
    check("disp_m5", display_data,
          {CHAR_P, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_DASH, CHAR_5});

    convert(16'd0, CHAR_BLK, CHAR_BLK, 8'h00, lat);
    check("disp_zero", display_data,
          {CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_0});

    convert(16'h7FFF, CHAR_BLK, CHAR_BLK, 8'h00, lat);
    check("lat_32767",  lat, 17);
    check("disp_32767", display_data,
          {CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_3, CHAR_2, CHAR_7, CHAR_6, CHAR_7});

    // Back-to-back: valid held from the first accept through the next IDLE cycle.
    while (!req_ready) step();
    req_valid = 1'b1;
    value     = 16'd100;
    prefix[1] = CHAR_BLK;
    prefix[0] = CHAR_BLK;
    blink_sel = 8'h00;
    step();
    value = 16'd200;
    n    = 0;
    seen = 1'b0;
    while (n < 40) begin
      step();
      n++;
      if (req_ready) begin
        seen = 1'b1;
        if (n == 17) begin
          check("b2b_first", display_data,
                {CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_1, CHAR_0, CHAR_0});
        end
      end else if (seen) begin
        break;
      end
    end
    check("b2b_spacing", n, 18);
    req_valid = 1'b0;
    while (n < 34) begin
      step();
      n++;
    end
    check("b2b_hold", display_data,
          {CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_1, CHAR_0, CHAR_0});
    step();
    check("b2b_second", display_data,
          {CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_BLK, CHAR_2, CHAR_0, CHAR_0});

    // Blink with BLINK_DIV=4: four lit cycles, four cycles with slots 1..0 dark.
    convert(16'd7, CHAR_BLK, CHAR_BLK, 8'h03, lat);
    for (int j = 0; j < 16; j++) begin
      check($sformatf("blink_%0d", j), blink_mask, ((j / 4) % 2 == 0) ? 8'hFF : 8'hFC);
      step();
    end
    step();
    convert(16'd8, CHAR_BLK, CHAR_BLK, 8'h03, lat);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("reblink_%0d", j), blink_mask, (j < 4) ? 8'hFF : 8'hFC);
      step();
    end

    // Asynchronous reset in the middle of a conversion.
    while (!req_ready) step();
    req_valid = 1'b1;
    value     = 16'd1234;
    prefix[1] = CHAR_A;
    prefix[0] = CHAR_BLK;
    blink_sel = 8'h00;
    step();
    req_valid = 1'b0;
    for (int j = 0; j < 5; j++) step();
    rst_n = 1'b0;
    #2;
    check("midrst_disp",  display_data, {8{CHAR_DASH}});
    check("midrst_mask",  blink_mask, 8'hFF);
    check("midrst_ready", req_ready, 1'b1);
    check("midrst_busy",  busy, 1'b0);
    step();
    rst_n = 1'b1;
    for (int j = 0; j < 25; j++) step();
    check("postrst_disp",  display_data, {8{CHAR_DASH}});
    check("postrst_ready", req_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
